// File: rtl/uvmt_cv32e40s_pma_resp_tracker.sv
// uvmt_cv32e40s_pma_resp_tracker
//
// Purpose: predicts the PMA attributes of each OBI transaction at the address phase.
// Each prediction waits in a per-channel FIFO until the response phase arrives.
// When the response arrives the prediction is retired and presented for one cycle
// as a registered pulse.
//
// Channel 0 is the instruction side and channel 1 is the data side.
//
// Ports (per channel c, packed as vectors):
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_i / req_gnt_i        address-phase handshake; accept = valid && gnt
//   req_addr_i[32*c +: 32]         byte address
//   req_we_i / req_dbg_i           write, debug-mode qualifiers
//   req_misaligned_i/req_pushpop_i misaligned and push/pop qualifiers
//   rsp_rvalid_i                   response-phase valid, retires FIFO head
//   exp_valid_o                    one-cycle pulse: exp_* hold a fresh retirement
//   exp_allow_o .. exp_integrity_o expected attributes of the retired transaction
//   exp_match_idx_o[5*c +: 5]      matched region, 16 = no match or debug override
//   outstanding_o[3*c +: 3]        FIFO occupancy
//   err_overflow_o/err_underflow_o sticky protocol-error flags
//
// Optional feature: define UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN to add
//   deny_count_o[16*c +: 16]       saturating count of retirements with allow=0
module uvmt_cv32e40s_pma_resp_tracker #(
    parameter int unsigned      PMA_NUM_REGIONS = 0,
    // Region i occupies PMA_CFG[i*68 +: 68]: [31:0] word_addr_low,
    // [63:32] word_addr_high, [64] main, [65] bufferable, [66] cacheable,
    // [67] integrity.
    parameter logic [16*68-1:0] PMA_CFG         = '0,
    parameter logic [31:0]      DM_REGION_START = 32'h1A11_0800,
    parameter logic [31:0]      DM_REGION_END   = 32'h1A11_0FFF,
    parameter int unsigned      NUM_CHANNELS    = 2,
    parameter int unsigned      FIFO_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CHANNELS-1:0]    req_valid_i,
    input  logic [NUM_CHANNELS-1:0]    req_gnt_i,
    input  logic [32*NUM_CHANNELS-1:0] req_addr_i,
    input  logic [NUM_CHANNELS-1:0]    req_we_i,
    input  logic [NUM_CHANNELS-1:0]    req_dbg_i,
    input  logic [NUM_CHANNELS-1:0]    req_misaligned_i,
    input  logic [NUM_CHANNELS-1:0]    req_pushpop_i,
    input  logic [NUM_CHANNELS-1:0]    rsp_rvalid_i,
    output logic [NUM_CHANNELS-1:0]    exp_valid_o,
    output logic [NUM_CHANNELS-1:0]    exp_allow_o,
    output logic [NUM_CHANNELS-1:0]    exp_main_o,
    output logic [NUM_CHANNELS-1:0]    exp_bufferable_o,
    output logic [NUM_CHANNELS-1:0]    exp_cacheable_o,
    output logic [NUM_CHANNELS-1:0]    exp_integrity_o,
    output logic [5*NUM_CHANNELS-1:0]  exp_match_idx_o,
    output logic [3*NUM_CHANNELS-1:0]  outstanding_o,
    output logic [NUM_CHANNELS-1:0]    err_overflow_o,
    output logic [NUM_CHANNELS-1:0]    err_underflow_o
`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
    ,
    output logic [16*NUM_CHANNELS-1:0] deny_count_o
`endif
);

    localparam int unsigned CfgW    = 68;
    localparam logic [4:0]  NoMatch = 5'd16;

    typedef struct packed {
        logic       allow;
        logic       main;
        logic       bufferable;
        logic       cacheable;
        logic       integrity;
        logic [4:0] match_idx;
    } entry_t;

    function automatic entry_t lookup(input logic [31:0] addr, input logic dbg,
                                      input logic we, input logic mis, input logic pp,
                                      input int unsigned ch);
        entry_t          e;
        logic            found;
        logic [CfgW-1:0] cfg;
        logic [33:0]     a34;
        a34         = {2'b00, addr};
        e           = '0;
        e.main      = (PMA_NUM_REGIONS == 0);
        e.match_idx = NoMatch;
        found       = 1'b0;
        // Regions are word-addressed; compare in 34 bits so high=32'hFFFF_FFFF covers the top.
        for (int i = 0; i < 16; i++) begin
            cfg = PMA_CFG[i*CfgW +: CfgW];
            if (!found && (i < int'(PMA_NUM_REGIONS)) &&
                (a34 >= {cfg[31:0], 2'b00}) && (a34 < {cfg[63:32], 2'b00})) begin
                found        = 1'b1;
                e.main       = cfg[64];
                e.bufferable = cfg[65];
                e.cacheable  = cfg[66];
                e.integrity  = cfg[67];
                e.match_idx  = 5'(i);
            end
        end
        // Debug-mode accesses to the debug module bypass the region table.
        if (dbg && (addr >= DM_REGION_START) && (addr <= DM_REGION_END)) begin
            e           = '0;
            e.main      = 1'b1;
            e.match_idx = NoMatch;
        end
        if ((ch == 0) || !we) begin
            e.bufferable = 1'b0;
        end
        e.allow = (ch == 0) ? e.main : (e.main || (!mis && !pp));
        return e;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        // Sized for the maximum depth so a 2-bit pointer indexes it exactly.
        entry_t     mem_q [4];
        logic [1:0] wr_ptr_q, rd_ptr_q;
        logic [2:0] count_q;
        logic       exp_valid_q, ovf_q, unf_q;
        entry_t     exp_q, head, push_entry;
        logic       push_req, pop_req, full, empty, do_push, do_pop;

        assign push_entry = lookup(req_addr_i[32*c +: 32], req_dbg_i[c], req_we_i[c],
                                   req_misaligned_i[c], req_pushpop_i[c], c);

        always_comb begin
            head     = mem_q[rd_ptr_q];
            push_req = req_valid_i[c] && req_gnt_i[c];
            pop_req  = rsp_rvalid_i[c];
            full     = (count_q == 3'(FIFO_DEPTH));
            empty    = (count_q == 3'd0);
            do_pop   = pop_req && !empty;
            // A full FIFO still accepts when the head leaves in the same cycle.
            do_push  = push_req && (!full || do_pop);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    mem_q[i] <= '0;
                end
                wr_ptr_q    <= 2'd0;
                rd_ptr_q    <= 2'd0;
                count_q     <= 3'd0;
                exp_valid_q <= 1'b0;
                exp_q       <= '0;
                ovf_q       <= 1'b0;
                unf_q       <= 1'b0;
            end else begin
                if (do_push) begin
                    mem_q[wr_ptr_q] <= push_entry;
                    wr_ptr_q        <= next_ptr(wr_ptr_q);
                end
                if (do_pop) begin
                    rd_ptr_q <= next_ptr(rd_ptr_q);
                    exp_q    <= head;
                end
                if (do_push && !do_pop) begin
                    count_q <= count_q + 3'd1;
                end else if (do_pop && !do_push) begin
                    count_q <= count_q - 3'd1;
                end
                exp_valid_q <= do_pop;
                if (push_req && full && !do_pop) begin
                    ovf_q <= 1'b1;
                end
                if (pop_req && empty) begin
                    unf_q <= 1'b1;
                end
            end
        end

        assign exp_valid_o[c]          = exp_valid_q;
        assign exp_allow_o[c]          = exp_q.allow;
        assign exp_main_o[c]           = exp_q.main;
        assign exp_bufferable_o[c]     = exp_q.bufferable;
        assign exp_cacheable_o[c]      = exp_q.cacheable;
        assign exp_integrity_o[c]      = exp_q.integrity;
        assign exp_match_idx_o[5*c +: 5] = exp_q.match_idx;
        assign outstanding_o[3*c +: 3]   = count_q;
        assign err_overflow_o[c]       = ovf_q;
        assign err_underflow_o[c]      = unf_q;

`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
        logic [15:0] deny_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deny_q <= 16'd0;
            end else if (do_pop && !head.allow && (deny_q != 16'hFFFF)) begin
                deny_q <= deny_q + 16'd1;
            end
        end

        assign deny_count_o[16*c +: 16] = deny_q;
`endif
    end

endmodule

// File: tb/tb_uvmt_cv32e40s_pma_resp_tracker.sv
// Bench for uvmt_cv32e40s_pma_resp_tracker.
// Two instances share one stimulus stream: dut A has no PMA regions and depth 2;
// dut B has three active regions (a fourth is configured but must be ignored) and depth 3.
module tb_uvmt_cv32e40s_pma_resp_tracker;

    localparam logic [31:0] DmStart = 32'h1A11_0800;
    localparam logic [31:0] DmEnd   = 32'h1A11_0FFF;

    // {integrity, cacheable, bufferable, main, word_high, word_low}
    function automatic logic [1087:0] mk_cfg_b();
        logic [1087:0] v;
        v = '0;
        v[0*68 +: 68] = {1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0000};
        v[1*68 +: 68] = {1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0800, 32'h0000_0000};
        v[2*68 +: 68] = {1'b0, 1'b1, 1'b1, 1'b0, 32'h0684_8000, 32'h0684_4000};
        v[3*68 +: 68] = {1'b1, 1'b1, 1'b1, 1'b0, 32'h3FFF_FFFF, 32'h0000_0000};
        return v;
    endfunction
    localparam logic [1087:0] CfgB = mk_cfg_b();

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_gnt, req_we, req_dbg, req_mis, req_pp, rsp_rvalid;
    logic [63:0] req_addr;
    logic [1:0]  a_ev, a_allow, a_main, a_buf, a_cache, a_integ, a_ovf, a_unf;
    logic [1:0]  b_ev, b_allow, b_main, b_buf, b_cache, b_integ, b_ovf, b_unf;
    logic [9:0]  a_idx, b_idx;
    logic [5:0]  a_out, b_out;
`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
    logic [31:0] a_deny, b_deny;
`endif

    always #5 clk = ~clk;

    uvmt_cv32e40s_pma_resp_tracker #(
        .PMA_NUM_REGIONS(0), .FIFO_DEPTH(2), .NUM_CHANNELS(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_gnt_i(req_gnt),
        .req_addr_i(req_addr), .req_we_i(req_we), .req_dbg_i(req_dbg),
        .req_misaligned_i(req_mis), .req_pushpop_i(req_pp), .rsp_rvalid_i(rsp_rvalid),
        .exp_valid_o(a_ev), .exp_allow_o(a_allow), .exp_main_o(a_main),
        .exp_bufferable_o(a_buf), .exp_cacheable_o(a_cache), .exp_integrity_o(a_integ),
        .exp_match_idx_o(a_idx), .outstanding_o(a_out), .err_overflow_o(a_ovf),
        .err_underflow_o(a_unf)
`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
        , .deny_count_o(a_deny)
`endif
    );

    uvmt_cv32e40s_pma_resp_tracker #(
        .PMA_NUM_REGIONS(3), .PMA_CFG(CfgB), .FIFO_DEPTH(3), .NUM_CHANNELS(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_gnt_i(req_gnt),
        .req_addr_i(req_addr), .req_we_i(req_we), .req_dbg_i(req_dbg),
        .req_misaligned_i(req_mis), .req_pushpop_i(req_pp), .rsp_rvalid_i(rsp_rvalid),
        .exp_valid_o(b_ev), .exp_allow_o(b_allow), .exp_main_o(b_main),
        .exp_bufferable_o(b_buf), .exp_cacheable_o(b_cache), .exp_integrity_o(b_integ),
        .exp_match_idx_o(b_idx), .outstanding_o(b_out), .err_overflow_o(b_ovf),
        .err_underflow_o(b_unf)
`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
        , .deny_count_o(b_deny)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       allow;
        logic       main;
        logic       bufferable;
        logic       cacheable;
        logic       integrity;
        logic [4:0] idx;
    } ent_t;

    ent_t        mq [4][$];    // index = dut*2 + channel
    ent_t        m_exp [4];
    logic        m_ev [4];
    logic        m_ovf [4];
    logic        m_unf [4];
    int unsigned m_deny [4];
    int          n_pass = 0;
    int          n_checks = 0;

    function automatic ent_t ref_lookup(input int d, input logic [31:0] addr, input logic dbg,
                                        input logic we, input logic mis, input logic pp,
                                        input int ch);
        ent_t   e;
        int     nreg;
        longint lo, hi, a;
        nreg = (d == 0) ? 0 : 3;
        e = '0;
        e.main = (nreg == 0);
        e.idx = 5'd16;
        a = longint'({32'h0, addr});
        if (dbg && addr >= DmStart && addr <= DmEnd) begin
            e.main = 1'b1;
        end else begin
            // Scan downward so the lowest matching region is the one left standing.
            for (int i = nreg - 1; i >= 0; i--) begin
                lo = longint'({32'h0, CfgB[i*68 +: 32]}) * 4;
                hi = longint'({32'h0, CfgB[i*68+32 +: 32]}) * 4;
                if (a >= lo && a < hi) begin
                    e.main       = CfgB[i*68+64];
                    e.bufferable = CfgB[i*68+65];
                    e.cacheable  = CfgB[i*68+66];
                    e.integrity  = CfgB[i*68+67];
                    e.idx        = 5'(i);
                end
            end
        end
        e.bufferable = e.bufferable && (ch == 1) && we;
        e.allow = (ch == 0) ? e.main : (e.main || !(mis || pp));
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            m_exp[k] = '0;
            m_ev[k] = 1'b0;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
            m_deny[k] = 0;
        end
    endtask

    task automatic model_update();
        int   k, sz, depth;
        logic popped;
        ent_t e;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                k = d * 2 + c;
                sz = mq[k].size();
                depth = (d == 0) ? 2 : 3;
                popped = 1'b0;
                e = ref_lookup(d, req_addr[32*c +: 32], req_dbg[c], req_we[c], req_mis[c],
                               req_pp[c], c);
                m_ev[k] = 1'b0;
                if (rsp_rvalid[c]) begin
                    if (sz > 0) begin
                        m_exp[k] = mq[k].pop_front();
                        m_ev[k] = 1'b1;
                        popped = 1'b1;
                        if (!m_exp[k].allow && m_deny[k] < 65535) m_deny[k]++;
                    end else begin
                        m_unf[k] = 1'b1;
                    end
                end
                if (req_valid[c] && req_gnt[c]) begin
                    if (sz < depth || popped) mq[k].push_back(e);
                    else m_ovf[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [15:0] obs(input int d, input int c);
        if (d == 0)
            return {a_ev[c], a_allow[c], a_main[c], a_buf[c], a_cache[c], a_integ[c],
                    a_idx[5*c +: 5], a_out[3*c +: 3], a_ovf[c], a_unf[c]};
        return {b_ev[c], b_allow[c], b_main[c], b_buf[c], b_cache[c], b_integ[c],
                b_idx[5*c +: 5], b_out[3*c +: 3], b_ovf[c], b_unf[c]};
    endfunction

    function automatic logic [15:0] model_vec(input int k);
        return {m_ev[k], m_exp[k].allow, m_exp[k].main, m_exp[k].bufferable,
                m_exp[k].cacheable, m_exp[k].integrity, m_exp[k].idx,
                3'(mq[k].size()), m_ovf[k], m_unf[k]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        req_valid = '0; req_gnt = '0; req_we = '0; req_dbg = '0;
        req_mis = '0; req_pp = '0; rsp_rvalid = '0; req_addr = '0;
    endtask

    task automatic drive_req(input int c, input logic [31:0] addr, input logic dbg,
                             input logic we, input logic mis, input logic pp);
        req_valid[c] = 1'b1; req_gnt[c] = 1'b1; req_addr[32*c +: 32] = addr;
        req_dbg[c] = dbg; req_we[c] = we; req_mis[c] = mis; req_pp[c] = pp;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] t [12];
        t = '{32'h0, 32'h7FC, 32'hFFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h1A11_07FF,
              32'h1A11_0800, 32'h1A11_0FFF, 32'h1A11_1000, 32'h1A11_FFFF, 32'h1A12_0000};
        if ($urandom_range(0, 3) == 0) return $urandom;
        return t[$urandom_range(0, 11)];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({a_ev, a_allow, a_main, a_buf, a_cache, a_integ, a_idx, a_out, a_ovf, a_unf} !== '0)
            $display("FAIL reset_a: got %h required 0",
                     {a_ev, a_allow, a_main, a_buf, a_cache, a_integ, a_idx, a_out, a_ovf, a_unf});
        else n_pass++;
        n_checks++;
        if ({b_ev, b_allow, b_main, b_buf, b_cache, b_integ, b_idx, b_out, b_ovf, b_unf} !== '0)
            $display("FAIL reset_b: got %h required 0",
                     {b_ev, b_allow, b_main, b_buf, b_cache, b_integ, b_idx, b_out, b_ovf, b_unf});
        else n_pass++;
    endtask

    task automatic test_default_main();
        idle(); drive_req(0, 32'h0000_1000, 0, 0, 0, 0); cycle();
        idle(); cycle();
        rsp_rvalid[0] = 1'b1; cycle(); idle();
        n_checks++;
        if ({a_ev[0], a_allow[0], a_main[0], a_idx[4:0]} !== {3'b111, 5'd16})
            $display("FAIL no_region_default: got %b required %b",
                     {a_ev[0], a_allow[0], a_main[0], a_idx[4:0]}, {3'b111, 5'd16});
        else n_pass++;
        n_checks++;
        if ({b_ev[0], b_allow[0], b_main[0], b_buf[0], b_cache[0], b_integ[0], b_idx[4:0]}
            !== {6'b111001, 5'd1})
            $display("FAIL region1_ch0: got %b required %b",
                     {b_ev[0], b_allow[0], b_main[0], b_buf[0], b_cache[0], b_integ[0],
                      b_idx[4:0]}, {6'b111001, 5'd1});
        else n_pass++;
        cycle();
        n_checks++;
        if ({a_ev[0], a_main[0], a_idx[4:0]} !== {2'b01, 5'd16})
            $display("FAIL exp_pulse_hold: got %b required %b",
                     {a_ev[0], a_main[0], a_idx[4:0]}, {2'b01, 5'd16});
        else n_pass++;
    endtask

    task automatic test_region_priority();
        idle(); drive_req(1, 32'h0000_0800, 0, 1, 1, 0); cycle();
        idle(); rsp_rvalid[1] = 1'b1; drive_req(1, 32'h0000_1800, 0, 1, 0, 0); cycle(); idle();
        n_checks++;
        if ({b_ev[1], b_allow[1], b_main[1], b_buf[1], b_cache[1], b_integ[1], b_idx[9:5]}
            !== {6'b100010, 5'd0})
            $display("FAIL lowest_region_wins: got %b required %b",
                     {b_ev[1], b_allow[1], b_main[1], b_buf[1], b_cache[1], b_integ[1],
                      b_idx[9:5]}, {6'b100010, 5'd0});
        else n_pass++;
        n_checks++;
        if ({a_ev[1], a_allow[1], a_main[1], a_buf[1], a_idx[9:5]} !== {4'b1110, 5'd16})
            $display("FAIL no_region_ch1: got %b required %b",
                     {a_ev[1], a_allow[1], a_main[1], a_buf[1], a_idx[9:5]}, {4'b1110, 5'd16});
        else n_pass++;
        rsp_rvalid[1] = 1'b1; cycle(); idle();
        n_checks++;
        if ({b_ev[1], b_allow[1], b_main[1], b_buf[1], b_cache[1], b_integ[1], b_idx[9:5]}
            !== {6'b111101, 5'd1})
            $display("FAIL bufferable_write_ch1: got %b required %b",
                     {b_ev[1], b_allow[1], b_main[1], b_buf[1], b_cache[1], b_integ[1],
                      b_idx[9:5]}, {6'b111101, 5'd1});
        else n_pass++;
    endtask

    task automatic test_dm_override();
        idle(); drive_req(0, 32'h1A11_0800, 1, 0, 0, 0); cycle();
        drive_req(0, 32'h1A11_0800, 0, 0, 0, 0); cycle(); idle();
        rsp_rvalid[0] = 1'b1; cycle(); idle();
        n_checks++;
        if ({b_ev[0], b_allow[0], b_main[0], b_buf[0], b_cache[0], b_integ[0], b_idx[4:0]}
            !== {6'b111000, 5'd16})
            $display("FAIL dm_override: got %b required %b",
                     {b_ev[0], b_allow[0], b_main[0], b_buf[0], b_cache[0], b_integ[0],
                      b_idx[4:0]}, {6'b111000, 5'd16});
        else n_pass++;
        rsp_rvalid[0] = 1'b1; cycle(); idle();
        n_checks++;
        if ({b_ev[0], b_allow[0], b_main[0], b_buf[0], b_cache[0], b_integ[0], b_idx[4:0]}
            !== {6'b100010, 5'd2})
            $display("FAIL dm_no_dbg: got %b required %b",
                     {b_ev[0], b_allow[0], b_main[0], b_buf[0], b_cache[0], b_integ[0],
                      b_idx[4:0]}, {6'b100010, 5'd2});
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] addrs [4];
        logic [4:0]  want_idx [3];
        logic        want_a_ev [3];
        addrs = '{32'h0000_0800, 32'h0000_1800, 32'h1A11_1000, 32'h0000_5000};
        want_idx = '{5'd0, 5'd1, 5'd2};
        want_a_ev = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); drive_req(0, addrs[i], 0, 0, 0, 0); cycle();
        end
        idle();
        n_checks++;
        if ({a_out[2:0], a_ovf[0], b_out[2:0], b_ovf[0]} !== {3'd2, 1'b1, 3'd3, 1'b1})
            $display("FAIL overflow: got %b required %b",
                     {a_out[2:0], a_ovf[0], b_out[2:0], b_ovf[0]}, {3'd2, 1'b1, 3'd3, 1'b1});
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            rsp_rvalid[0] = 1'b1; cycle(); idle();
            n_checks++;
            if ({b_ev[0], b_idx[4:0], a_ev[0]} !== {1'b1, want_idx[j], want_a_ev[j]})
                $display("FAIL retire_order_%0d: got %b required %b", j,
                         {b_ev[0], b_idx[4:0], a_ev[0]}, {1'b1, want_idx[j], want_a_ev[j]});
            else n_pass++;
        end
        n_checks++;
        if ({a_unf[0], a_out[2:0], b_ovf[0], b_unf[0]} !== {1'b1, 3'd0, 1'b1, 1'b0})
            $display("FAIL sticky_after_drain: got %b required %b",
                     {a_unf[0], a_out[2:0], b_ovf[0], b_unf[0]}, {1'b1, 3'd0, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_underflow_reset();
        do_reset();
        rsp_rvalid[1] = 1'b1; drive_req(1, 32'h0000_0800, 0, 0, 0, 0); cycle(); idle();
        n_checks++;
        if ({a_ev[1], a_unf[1], a_out[5:3], b_ev[1], b_unf[1]} !== {2'b01, 3'd1, 2'b01})
            $display("FAIL underflow_push: got %b required %b",
                     {a_ev[1], a_unf[1], a_out[5:3], b_ev[1], b_unf[1]}, {2'b01, 3'd1, 2'b01});
        else n_pass++;
        drive_req(0, 32'h0000_0100, 0, 0, 0, 0); drive_req(1, 32'h0000_1800, 0, 1, 0, 0); cycle();
        rsp_rvalid[1] = 1'b1; cycle(); idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({a_ev, a_allow, a_main, a_buf, a_cache, a_integ, a_idx, a_out, a_ovf, a_unf,
             b_ev, b_allow, b_main, b_buf, b_cache, b_integ, b_idx, b_out, b_ovf, b_unf} !== '0)
            $display("FAIL async_reset: got %h required 0",
                     {a_ev, a_allow, a_main, a_buf, a_cache, a_integ, a_idx, a_out, a_ovf, a_unf,
                      b_ev, b_allow, b_main, b_buf, b_cache, b_integ, b_idx, b_out, b_ovf, b_unf});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(0, 32'h0000_1000, 0, 0, 0, 0); cycle(); idle();
        n_checks++;
        if ({a_out[2:0], b_out[2:0]} !== {3'd1, 3'd1})
            $display("FAIL first_accept: got %b required %b", {a_out[2:0], b_out[2:0]},
                     {3'd1, 3'd1});
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] got, want;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            idle();
            for (int c = 0; c < 2; c++) begin
                req_valid[c] = ($urandom_range(0, 2) != 0);
                req_gnt[c] = ($urandom_range(0, 3) != 0);
                req_addr[32*c +: 32] = pick_addr();
                req_dbg[c] = ($urandom_range(0, 3) == 0);
                req_we[c] = $urandom_range(0, 1);
                req_mis[c] = ($urandom_range(0, 3) == 0);
                req_pp[c] = ($urandom_range(0, 3) == 0);
                rsp_rvalid[c] = ($urandom_range(0, 9) < 4);
            end
            cycle();
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    got = obs(d, c);
                    want = model_vec(d * 2 + c);
                    n_checks++;
                    if (got !== want)
                        $display("FAIL random dut%0d ch%0d cyc %0d: got %h required %h",
                                 d, c, n, got, want);
                    else n_pass++;
                end
            end
`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
            n_checks++;
            if ({b_deny, a_deny} !== {16'(m_deny[3]), 16'(m_deny[2]), 16'(m_deny[1]),
                                      16'(m_deny[0])})
                $display("FAIL random_deny cyc %0d: got %h required %h", n, {b_deny, a_deny},
                         {16'(m_deny[3]), 16'(m_deny[2]), 16'(m_deny[1]), 16'(m_deny[0])});
            else n_pass++;
`endif
        end
        idle();
    endtask

`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(1, 32'h0000_0800, 0, 0, 1, 0); cycle(); idle();
            rsp_rvalid[1] = 1'b1; cycle(); idle();
        end
        n_checks++;
        if ({b_deny, a_deny} !== {16'd4, 16'd0, 16'd0, 16'd0})
            $display("FAIL deny_count: got %h required %h", {b_deny, a_deny},
                     {16'd4, 16'd0, 16'd0, 16'd0});
        else n_pass++;
    endtask
`endif

    initial begin
        idle();
        model_reset();
        test_reset();
        test_default_main();
        test_region_priority();
        test_dm_override();
        test_overflow();
        test_underflow_reset();
        test_random();
`ifdef UVMT_CV32E40S_PMA_RESP_TRACKER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
